// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: WIDTH-bit dividend over WIDTH/2-bit divisor,
// one quotient bit per cycle, with valid/ready handshakes on operands and result.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH/2-1:0]   divisor,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH/2-1:0]   remainder,
    output logic                 div_by_zero,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] dividend_sr;
    logic [HALF-1:0]  divisor_r;
    logic [HALF:0]    pr;
    logic [WIDTH-1:0] quot;
    logic [CW-1:0]    count;
    logic             dbz;

    logic             accept;
    logic             last_step;
    logic             fits;
    logic [HALF:0]    pr_shift;
    logic [HALF:0]    pr_sub;

    assign accept    = in_valid && in_ready;
    assign last_step = (count == CW'(1));
    assign pr_shift  = {pr[HALF-1:0], dividend_sr[WIDTH-1]};
    assign fits      = (pr_shift >= {1'b0, divisor_r});
    assign pr_sub    = pr_shift - {1'b0, divisor_r};

    assign quotient    = quot;
    assign remainder   = pr[HALF-1:0];
    assign div_by_zero = dbz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero divisor still passes through one BUSY cycle (with no step) so its
    // result shows up one edge after acceptance, like a one-step divide.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (dbz || last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dividend_sr <= '0;
            divisor_r   <= '0;
            pr          <= '0;
            quot        <= '0;
            count       <= '0;
            dbz         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dividend_sr <= dividend;
                        divisor_r   <= divisor;
                        if (divisor == '0) begin
                            quot  <= '1;
                            pr    <= {1'b0, dividend[HALF-1:0]};
                            dbz   <= 1'b1;
                            count <= '0;
                        end else begin
                            quot  <= '0;
                            pr    <= '0;
                            dbz   <= 1'b0;
                            count <= CW'(WIDTH);
                        end
                    end
                end
                BUSY: begin
                    if (!dbz) begin
                        dividend_sr <= dividend_sr << 1;
                        pr          <= fits ? pr_sub : pr_shift;
                        quot        <= {quot[WIDTH-2:0], fits};
                        count       <= count - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases, resets mid-operation and
// a randomized soak checked against plain integer division with exact latency.
module tb_div_seq;
    localparam int WIDTH = 32;
    localparam int HALF  = WIDTH / 2;

    logic              clk;
    logic              reset;
    logic [WIDTH-1:0]  dividend;
    logic [HALF-1:0]   divisor;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  quotient;
    logic [HALF-1:0]   remainder;
    logic              div_by_zero;
    logic              out_valid;
    logic              out_ready;

    int compared;
    int mismatched;

    div_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .dividend(dividend),
        .divisor(divisor),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts and ends right after a falling edge; garbage is driven on the
    // operand inputs while the block is busy to show it is ignored.
    task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [HALF-1:0] dvs, input int gap);
        logic [WIDTH-1:0] exp_q;
        logic [HALF-1:0]  exp_r;
        logic             exp_z;
        int               exp_lat;
        int               lat;
        logic             leak;
        logic             unstable;
        logic [WIDTH-1:0] q0;
        logic [HALF-1:0]  r0;
        logic             z0;

        if (dvs == '0) begin
            exp_q   = '1;
            exp_r   = dvd[HALF-1:0];
            exp_z   = 1'b1;
            exp_lat = 1;
        end else begin
            exp_q   = dvd / {{HALF{1'b0}}, dvs};
            exp_r   = HALF'(dvd % {{HALF{1'b0}}, dvs});
            exp_z   = 1'b0;
            exp_lat = WIDTH;
        end

        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 0;
        leak = 1'b0;
        while (!out_valid && lat < WIDTH + 10) begin
            if (in_ready) leak = 1'b1;
            in_valid  = 1'($urandom_range(0, 1));
            dividend  = $urandom;
            divisor   = HALF'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        if (in_ready) leak = 1'b1;
        checkOutput("latency", 64'(lat), 64'(exp_lat));
        checkOutput("in_ready_busy", 64'(leak), 64'd0);
        checkOutput("quotient", 64'(quotient), 64'(exp_q));
        checkOutput("remainder", 64'(remainder), 64'(exp_r));
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(exp_z));
        if (dvs != '0) begin
            checkOutput("identity", 64'(quotient) * 64'(dvs) + 64'(remainder), 64'(dvd));
            checkOutput("rem_lt_div", 64'(remainder < dvs), 64'd1);
        end

        q0 = quotient;
        r0 = remainder;
        z0 = div_by_zero;
        unstable = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor  = HALF'($urandom);
            @(negedge clk);
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0 || !out_valid || in_ready)
                unstable = 1'b1;
        end
        checkOutput("held_stable", 64'(unstable), 64'd0);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid_cleared", 64'(out_valid), 64'd0);
        checkOutput("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        int   waited;

        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        dividend   = '0;
        divisor    = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_quotient", 64'(quotient), 64'd0);
        checkOutput("rst_remainder", 64'(remainder), 64'd0);
        checkOutput("rst_dbz", 64'(div_by_zero), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] directed cases");
        applyStimulus(32'd100, 16'd7, 0);
        applyStimulus(32'hFFFF_FFFF, 16'h0001, 1);
        applyStimulus(32'hFFFF_FFFF, 16'hFFFF, 0);
        applyStimulus(32'h0000_0005, 16'hFFFF, 2);
        applyStimulus(32'h0000_04D2, 16'h0000, 0);
        applyStimulus(32'd123456, 16'd77, 0);
        applyStimulus(32'd1000, 16'd7, 5);

        $display("[TB] reset during BUSY");
        dividend = 32'd1000;
        divisor  = 16'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("busy_rst_quotient", 64'(quotient), 64'd0);
        checkOutput("busy_rst_remainder", 64'(remainder), 64'd0);
        checkOutput("busy_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (WIDTH + 8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("aborted_no_result", 64'(seen), 64'd0);
        applyStimulus(32'd1000, 16'd3, 0);

        $display("[TB] reset during DONE");
        dividend = 32'hFFFF_FFFF;
        divisor  = 16'h0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < WIDTH + 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("done_reached", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("done_rst_quotient", 64'(quotient), 64'd0);
        checkOutput("done_rst_remainder", 64'(remainder), 64'd0);
        checkOutput("done_rst_dbz", 64'(div_by_zero), 64'd0);
        checkOutput("done_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] random soak");
        for (int n = 0; n < 1000; n++) begin
            logic [WIDTH-1:0] a;
            logic [HALF-1:0]  b;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, WIDTH - 1);
            b = HALF'($urandom);
            if ($urandom_range(0, 9) == 0) b = '0;
            else if ($urandom_range(0, 4) == 0) b = HALF'($urandom_range(1, 15));
            applyStimulus(a, b, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
